// File: rtl/ray_scheduler_pkg.sv
// Shared types for the ray scheduler: camera vector, scheduler state and bus widths.
package ray_scheduler_pkg;
  localparam int COORD_W    = 16;
  localparam int SEL_BITS   = 3;
  localparam int COLOR_BITS = 4;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vec3;

  typedef enum logic [1:0] {
    SCH_Idle,
    SCH_Dispatch,
    SCH_Drain
  } SchedState;
endpackage

// File: rtl/ray_scheduler_if.sv
// Scheduler <-> ray_unit array and framebuffer write port; master is the scheduler side.
interface ray_scheduler_if
  import ray_scheduler_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 8,
  parameter int ADDR_BITS = 17
);
  logic [NUM_UNITS-1:0]                 unit_valid_out;
  logic [H_BITS-1:0]                    pix_hcount_out;
  logic [V_BITS-1:0]                    pix_vcount_out;
  logic [NUM_UNITS-1:0]                 unit_ready_in;
  logic [NUM_UNITS-1:0][H_BITS-1:0]     unit_hcount_in;
  logic [NUM_UNITS-1:0][V_BITS-1:0]     unit_vcount_in;
  logic [NUM_UNITS-1:0][COLOR_BITS-1:0] unit_color_in;
  logic                                 fb_we_out;
  logic [ADDR_BITS-1:0]                 fb_addr_out;
  logic [COLOR_BITS-1:0]                fb_data_out;

  modport master (
    output unit_valid_out, pix_hcount_out, pix_vcount_out,
    output fb_we_out, fb_addr_out, fb_data_out,
    input  unit_ready_in, unit_hcount_in, unit_vcount_in, unit_color_in
  );

  modport slave (
    input  unit_valid_out, pix_hcount_out, pix_vcount_out,
    input  fb_we_out, fb_addr_out, fb_data_out,
    output unit_ready_in, unit_hcount_in, unit_vcount_in, unit_color_in
  );
endinterface

// File: rtl/ray_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  // Walk from lowest to highest priority so the entry nearest ptr_q wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        ptr_d      = IW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ray_scheduler.sv
// Frame scheduler: dispatches raster pixels to a pool of ray units and funnels their results to the framebuffer.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_scheduler
  import ray_scheduler_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS,
  parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  vec3                 cam_origin_in,
  input  vec3                 cam_forward_in,
  input  logic [SEL_BITS-1:0] fractal_sel_in,
  output vec3                 ray_origin_out,
  output vec3                 cam_forward_out,
  output logic [SEL_BITS-1:0] fractal_sel_out,
  output logic                busy_out,
  output logic                frame_done_out,
  ray_scheduler_if.master     bus
);
  SchedState state_q, state_d;
  logic [H_BITS-1:0]     h_q, h_d, pix_h_q, wh;
  logic [V_BITS-1:0]     v_q, v_d, pix_v_q, wv;
  logic [COLOR_BITS-1:0] wcol, fb_data_q;
  logic [ADDR_BITS-1:0]  fb_addr_q;
  logic [NUM_UNITS-1:0]  inflight_q, pending_q, ready_prev_q, valid_q;
  logic [NUM_UNITS-1:0]  elig, dreq, dgnt, wgnt, done_unit;
  logic                  start_acc, done_d, last_pix, fb_we_q, done_q;
  vec3                   org_q, fwd_q;
  logic [SEL_BITS-1:0]   sel_q;

  // A unit just given work is excluded even before its ready drops.
  assign elig      = bus.unit_ready_in & ~inflight_q & ~pending_q & ~valid_q;
  assign dreq      = (state_q == SCH_Dispatch) ? elig : '0;
  assign done_unit = inflight_q & bus.unit_ready_in & ~ready_prev_q;
  assign last_pix  = (h_q == H_BITS'(DISPLAY_WIDTH - 1)) && (v_q == V_BITS'(DISPLAY_HEIGHT - 1));

  rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
    .clk_i(clk_in), .rst_i(rst_in), .req_i(dreq), .gnt_o(dgnt)
  );

  rr_arbiter #(.N(NUM_UNITS)) u_wr_arb (
    .clk_i(clk_in), .rst_i(rst_in), .req_i(pending_q), .gnt_o(wgnt)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      SCH_Idle: if (start_in) begin
        state_d   = SCH_Dispatch;
        start_acc = 1'b1;
      end
      SCH_Dispatch: if (|dgnt && last_pix) state_d = SCH_Drain;
      SCH_Drain: if (inflight_q == '0 && pending_q == '0) begin
        state_d = SCH_Idle;
        done_d  = 1'b1;
      end
      default: state_d = SCH_Idle;
    endcase
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (start_acc) begin
      h_d = '0;
      v_d = '0;
    end else if (|dgnt) begin
      if (h_q == H_BITS'(DISPLAY_WIDTH - 1)) begin
        h_d = '0;
        v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    wh   = '0;
    wv   = '0;
    wcol = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (wgnt[i]) begin
        wh   = bus.unit_hcount_in[i];
        wv   = bus.unit_vcount_in[i];
        wcol = bus.unit_color_in[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= SCH_Idle;
    else        state_q <= state_d;
  end

  // Flag updates: dispatch/completion touch disjoint units, as do completion/write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_q          <= '0;
      v_q          <= '0;
      inflight_q   <= '0;
      pending_q    <= '0;
      ready_prev_q <= '0;
      valid_q      <= '0;
      pix_h_q      <= '0;
      pix_v_q      <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      done_q       <= 1'b0;
      org_q        <= '0;
      fwd_q        <= '0;
      sel_q        <= '0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      inflight_q   <= (inflight_q | dgnt) & ~done_unit;
      pending_q    <= (pending_q | done_unit) & ~wgnt;
      ready_prev_q <= bus.unit_ready_in;
      valid_q      <= dgnt;
      fb_we_q      <= |wgnt;
      done_q       <= done_d;
      if (|dgnt) begin
        pix_h_q <= h_q;
        pix_v_q <= v_q;
      end
      if (|wgnt) begin
        fb_addr_q <= ADDR_BITS'(wv) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(wh);
        fb_data_q <= wcol;
      end
      if (start_acc) begin
        org_q <= cam_origin_in;
        fwd_q <= cam_forward_in;
        sel_q <= fractal_sel_in;
      end
    end
  end

  assign bus.unit_valid_out = valid_q;
  assign bus.pix_hcount_out = pix_h_q;
  assign bus.pix_vcount_out = pix_v_q;
  assign bus.fb_we_out      = fb_we_q;
  assign bus.fb_addr_out    = fb_addr_q;
  assign bus.fb_data_out    = fb_data_q;
  assign ray_origin_out     = org_q;
  assign cam_forward_out    = fwd_q;
  assign fractal_sel_out    = sel_q;
  assign busy_out           = (state_q != SCH_Idle);
  assign frame_done_out     = done_q;
endmodule

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 Parameter NUM_UNITS, default 4: number of ray_unit instances served.
REQ-002 Parameters DISPLAY_WIDTH, DISPLAY_HEIGHT, H_BITS, V_BITS: defaults `DISPLAY_WIDTH, `DISPLAY_HEIGHT, `H_BITS, `V_BITS; frame geometry.
REQ-003 Parameter ADDR_BITS, default $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT): framebuffer address width.
REQ-004 clk_in  input  1  sole clock; all logic on posedge clk_in.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 start_in  input  1  request to render one frame.
REQ-007 cam_origin_in, cam_forward_in  input  vec3 each  camera; fractal_sel_in  input  3  scene select.
REQ-008 ray_origin_out, cam_forward_out  output  vec3 each; fractal_sel_out  output  3  broadcast to all units.
REQ-009 pix_hcount_out  output  H_BITS; pix_vcount_out  output  V_BITS  pixel broadcast to all units.
REQ-010 unit_valid_out  output  NUM_UNITS  one-hot dispatch strobe, bit i drives unit i valid_in.
REQ-011 unit_ready_in  input  NUM_UNITS  unit i ready_out.
REQ-012 unit_hcount_in  input  NUM_UNITS x H_BITS; unit_vcount_in  input  NUM_UNITS x V_BITS; unit_color_in  input  NUM_UNITS x 4  unit results.
REQ-013 fb_we_out  output  1; fb_addr_out  output  ADDR_BITS; fb_data_out  output  4  framebuffer write port, always accepted.
REQ-014 busy_out  output  1  frame in progress; frame_done_out  output  1  one-cycle pulse at frame end.

Function
REQ-015 FSM states SCH_Idle, SCH_Dispatch, SCH_Drain; SCH_Idle -> SCH_Dispatch on start_in; SCH_Dispatch -> SCH_Drain after pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) dispatched; SCH_Drain -> SCH_Idle when no unit in flight and no result pending, pulsing frame_done_out that cycle.
REQ-016 On accepted start_in, latch cam_origin_in, cam_forward_in, fractal_sel_in into the broadcast outputs, held constant until next accepted start; reset pixel counter to (0,0).
REQ-017 start_in outside SCH_Idle ignored.
REQ-018 Unit i eligible when unit_ready_in[i]=1, in-flight flag clear, pending flag clear, and not dispatched in the previous cycle.
REQ-019 In SCH_Dispatch, at most one dispatch per cycle: round-robin pick among eligible units starting after last granted index; assert single unit_valid_out bit for exactly one cycle with current pixel on pix_*_out; set in-flight[i]; advance pixel raster order (h wraps at DISPLAY_WIDTH-1 to 0, v increments).
REQ-020 pix_*_out shall be stable in the dispatch cycle; unit_valid_out registered.
REQ-021 Completion of unit i: in-flight[i]=1 and unit_ready_in[i] rises 0->1 (registered prior value); clears in-flight[i], sets pending[i].
REQ-022 Write arbiter: at most one write per cycle, round-robin among pending units (independent pointer); fb_we_out=1, fb_addr_out=v*DISPLAY_WIDTH+h (ADDR_BITS, no overflow), fb_data_out=unit color; clears pending[i]; registered, one cycle after pending set at earliest.
REQ-023 Completion and write on same unit same cycle impossible by construction; completion on one unit and write on another same cycle both take effect.
REQ-024 Dispatch and write arbitration run concurrently; a unit freed by a write is eligible the following cycle.
REQ-025 Every pixel of a frame written exactly once; no dispatch when no unit eligible (stall, counter holds).
REQ-026 busy_out=1 in SCH_Dispatch and SCH_Drain.

Reset
REQ-027 rst_in asserted (any time, including mid-frame): state SCH_Idle, all in-flight/pending flags, arbitration pointers, pixel counter, unit_valid_out, fb_we_out, fb_addr_out, fb_data_out, frame_done_out, busy_out, pix_*_out cleared to 0; broadcast camera/fractal outputs 0; units reset by same rst_in, partial frame discarded.

Structure
REQ-028 SchedState enum and any shared constants in types.sv; vec3 from types.sv.
REQ-029 One sub-module rr_arbiter (NUM_UNITS request, one-hot grant, pointer advance on grant), instantiated twice (dispatch, write).

Verification
REQ-030 NUM_UNITS=4, 4x2 display, unit models with fixed 5-cycle latency: start -> 8 dispatches to units 0,1,2,3,0,1,2,3; 8 writes, addresses 0..7 each once; frame_done pulse once; busy_out falls same cycle.
REQ-031 Units 0..3 complete in same cycle -> four writes on consecutive cycles in round-robin order, none lost.
REQ-032 Unit 2 held not ready -> dispatches rotate among 0,1,3 only; frame completes.
REQ-033 start_in pulsed mid-frame with new camera -> ignored; broadcast camera unchanged until next frame.
REQ-034 rst_in asserted mid-dispatch for 1 cycle, async to edge -> outputs 0 immediately; fresh start renders full frame, 8 writes.
REQ-035 Per-unit latency randomized 1-40 cycles over 3 back-to-back frames -> every address written once per frame, fb_data_out matches model colour.
